nubus_slot_master: RTL and testbench
====================================

# nubus_slot_master

Initiator-side bridge between the 68000 CPU bus and a single NuBus slot card such as the slot video card. It turns a decoded CPU slot-window cycle into a slot select/ack transaction. It returns read data with DTACK, or BERR on timeout. It also synchronizes the card's interrupt request into the CPU clock domain.

## Interface
- SLOT_ID, 4'h9, slot number placed in address bits [27:24].
- TIMEOUT_CYCLES, 255, clocks in REQ without ack before bus error (1..65535).
- clk  in  1  system clock; same clock as the slot card.
- reset_n  in  1  reset, asynchronous assert, active-low.
- cpu_req  in  1  level; high while the CPU address strobe is active and the slot window is decoded.
- cpu_addr  in  23  CPU address [23:1].
- cpu_rw_n  in  1  1=read, 0=write.
- cpu_uds_n, cpu_lds_n  in  1 each  CPU byte strobes, active-low.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  read data; held until the next read completes.
- cpu_dtack_n  out  1  data acknowledge, active-low.
- cpu_berr_n  out  1  bus error, active-low.
- slot_irq  out  1  synchronized slot interrupt, active-high.
- nb_addr  out  32  equals {4'hF, SLOT_ID, cpu_addr, 1'b0}.
- nb_data  out  16  write data to the card.
- nb_uds_lds  out  2  byte enables, active-high; bit1 = upper byte.
- nb_rw_n  out  1  transfer direction to the card.
- nb_select  out  1  card select.
- nb_din  in  16  card read data.
- nb_ack_n  in  1  card acknowledge, active-low, registered by the card.
- nb_nmrq_n  in  1  card interrupt request, active-low, asynchronous to be safe.

## Operation
- Reset values:
  - nb_select=0, nb_addr=0, nb_data=0, nb_uds_lds=0, nb_rw_n=1.
  - cpu_dout=0, cpu_dtack_n=1, cpu_berr_n=1, slot_irq=0.
  - state=IDLE, timeout counter=0.
- States: IDLE, REQ, DONE.
- IDLE → REQ when all of these hold:
  - cpu_req=1;
  - (cpu_uds_n=0 or cpu_lds_n=0);
  - nb_ack_n=1. A stale ack blocks launch.
- On the IDLE → REQ edge:
  - register nb_addr, nb_data=cpu_din, nb_uds_lds={~cpu_uds_n,~cpu_lds_n}, nb_rw_n=cpu_rw_n;
  - set nb_select=1 and clear the counter.
- In REQ, the counter increments each clock.
- REQ → DONE on nb_ack_n=0:
  - nb_select=0;
  - cpu_dtack_n=0;
  - if nb_rw_n=1, cpu_dout=nb_din.
- REQ → DONE on timeout, when the counter reaches TIMEOUT_CYCLES-1 with nb_ack_n=1:
  - nb_select=0, cpu_berr_n=0;
  - cpu_dout unchanged, cpu_dtack_n stays 1.
- Ack and timeout on the same edge: ack wins, giving DTACK with no BERR.
- DONE holds DTACK/BERR. It exits to IDLE when cpu_req=0, releasing cpu_dtack_n=1 and cpu_berr_n=1 on that edge.
- cpu_req staying high after completion never launches a second transaction.
- cpu_req dropping during REQ (aborted CPU cycle) is ignored. The transaction completes or times out, then DONE exits immediately.
- nb_addr, nb_data, nb_uds_lds and nb_rw_n hold their values outside IDLE launch edges.
- slot_irq: two-flop synchronizer of ~nb_nmrq_n. Independent of the FSM.
- Counter width is 16 bits with no wrap: it saturates at TIMEOUT_CYCLES-1.

## Timing
- Edge 0: cpu_req sampled high in IDLE → nb_select=1 after edge 0.
- The card's registered ack appears at the earliest after edge 1. The master samples it at edge 2, so cpu_dtack_n=0 after edge 2 and nb_select is high for exactly 2 clocks.
- VRAM accesses stretch REQ until the card's SDRAM path returns; there is no upper bound other than the timeout.
- Read data is captured on the same edge ack is sampled. The card drives data_out and ack_n together, so data is valid at that edge.
- The card releases ack_n one clock after select falls. A new request is held in IDLE until nb_ack_n=1 is sampled.
- Timeout: cpu_berr_n=0 after exactly TIMEOUT_CYCLES clocks of nb_select=1.
- Async reset clears every output immediately, with no clock needed. Reset mid-REQ drops nb_select without waiting for ack.
- slot_irq latency: 2 clk edges after nb_nmrq_n changes.

## Test plan
- Register write: cpu_addr=23'h040000 (byte 0x080000), rw_n=0, uds_n=0, lds_n=1, din=16'h8000 → nb_addr=32'hF9080000, nb_uds_lds=2'b10, nb_data=16'h8000. nb_select rises 1 clk after cpu_req. cpu_dtack_n falls on the edge ack_n=0 is sampled, and nb_select falls on that same edge.
- ROM read: byte addr 0xF00010, card returns 16'h1234 → cpu_dout=16'h1234 when cpu_dtack_n falls. cpu_dout is still 16'h1234 after a subsequent write.
- Timeout, TIMEOUT_CYCLES=16, with a card model that never acks → cpu_berr_n=0 exactly 16 clks after nb_select rises, and cpu_dtack_n stays 1. Dropping cpu_req releases BERR on the next edge. In a second run, ack arriving on the 16th clk → DTACK, no BERR.
- Handshake ordering:
  - cpu_req held high through DONE for 10 clks → only one select pulse.
  - Force nb_ack_n=0 while cpu_req re-rises → nb_select stays 0 until nb_ack_n=1 is sampled.
- Async reset: assert reset_n=0 mid-REQ between clock edges → nb_select=0 and all outputs at reset values before the next edge. After release, a normal read completes.
- IRQ: nb_nmrq_n 1→0 → slot_irq=1 after 2 edges. nb_nmrq_n 0→1 → slot_irq=0 after 2 edges. An FSM transaction running concurrently is unaffected.

Source files
------------

// File: rtl/nubus_slot_master.sv
// CPU-to-NuBus slot initiator: launches one select/ack transaction per CPU slot cycle,
// returns DTACK with read data or BERR on timeout, and synchronizes the card interrupt.
module nubus_slot_master #(
  parameter logic [3:0]  SLOT_ID        = 4'h9,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [22:0] cpu_addr,
  input  logic        cpu_rw_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic        slot_irq,
  output logic [31:0] nb_addr,
  output logic [15:0] nb_data,
  output logic [1:0]  nb_uds_lds,
  output logic        nb_rw_n,
  output logic        nb_select,
  input  logic [15:0] nb_din,
  input  logic        nb_ack_n,
  input  logic        nb_nmrq_n
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt;
  logic        irq_meta;
  logic        launch, ack_hit, to_hit, release_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Ack is checked before the timeout so a same-edge ack completes normally.
  always_comb begin
    state_next   = state;
    launch       = 1'b0;
    ack_hit      = 1'b0;
    to_hit       = 1'b0;
    release_done = 1'b0;
    case (state)
      IDLE: if (cpu_req && (!cpu_uds_n || !cpu_lds_n) && nb_ack_n) begin
        launch     = 1'b1;
        state_next = REQ;
      end
      REQ: begin
        if (!nb_ack_n) begin
          ack_hit    = 1'b1;
          state_next = DONE;
        end else if (cnt == TO_LAST) begin
          to_hit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: if (!cpu_req) begin
        release_done = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nb_select   <= 1'b0;
      nb_addr     <= '0;
      nb_data     <= '0;
      nb_uds_lds  <= '0;
      nb_rw_n     <= 1'b1;
      cpu_dout    <= '0;
      cpu_dtack_n <= 1'b1;
      cpu_berr_n  <= 1'b1;
      cnt         <= '0;
    end else begin
      if (launch) begin
        nb_addr    <= {4'hF, SLOT_ID, cpu_addr, 1'b0};
        nb_data    <= cpu_din;
        nb_uds_lds <= {~cpu_uds_n, ~cpu_lds_n};
        nb_rw_n    <= cpu_rw_n;
        nb_select  <= 1'b1;
        cnt        <= '0;
      end
      if (state == REQ && cnt != TO_LAST) cnt <= cnt + 16'd1;
      if (ack_hit) begin
        nb_select   <= 1'b0;
        cpu_dtack_n <= 1'b0;
        if (nb_rw_n) cpu_dout <= nb_din;
      end
      if (to_hit) begin
        nb_select  <= 1'b0;
        cpu_berr_n <= 1'b0;
      end
      if (release_done) begin
        cpu_dtack_n <= 1'b1;
        cpu_berr_n  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_meta <= 1'b0;
      slot_irq <= 1'b0;
    end else begin
      irq_meta <= ~nb_nmrq_n;
      slot_irq <= irq_meta;
    end
  end

endmodule

// File: tb/tb_nubus_slot_master.sv
// Directed bench for nubus_slot_master with a hand-driven card (ack/data) and hand-computed expectations.
module tb_nubus_slot_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic [22:0] cpu_addr;
  logic        cpu_rw_n;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_dtack_n;
  logic        cpu_berr_n;
  logic        slot_irq;
  logic [31:0] nb_addr;
  logic [15:0] nb_data;
  logic [1:0]  nb_uds_lds;
  logic        nb_rw_n;
  logic        nb_select;
  logic [15:0] nb_din;
  logic        nb_ack_n;
  logic        nb_nmrq_n;

  int n_assert = 0;
  int n_fail   = 0;

  nubus_slot_master #(.SLOT_ID(4'h9), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rw_n(cpu_rw_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_dtack_n(cpu_dtack_n),
    .cpu_berr_n(cpu_berr_n), .slot_irq(slot_irq), .nb_addr(nb_addr),
    .nb_data(nb_data), .nb_uds_lds(nb_uds_lds), .nb_rw_n(nb_rw_n),
    .nb_select(nb_select), .nb_din(nb_din), .nb_ack_n(nb_ack_n),
    .nb_nmrq_n(nb_nmrq_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_select"}, 32'(nb_select),   32'd0);
    chk({tag, "_addr"},   nb_addr,          32'd0);
    chk({tag, "_data"},   32'(nb_data),     32'd0);
    chk({tag, "_be"},     32'(nb_uds_lds),  32'd0);
    chk({tag, "_rw"},     32'(nb_rw_n),     32'd1);
    chk({tag, "_dout"},   32'(cpu_dout),    32'd0);
    chk({tag, "_dtack"},  32'(cpu_dtack_n), 32'd1);
    chk({tag, "_berr"},   32'(cpu_berr_n),  32'd1);
    chk({tag, "_irq"},    32'(slot_irq),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    cpu_rw_n  = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    cpu_din   = '0;
    nb_din    = '0;
    nb_ack_n  = 1'b1;
    nb_nmrq_n = 1'b1;
    tick();
    tick();
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    // Register write: uds only
    cpu_addr = 23'h040000; cpu_rw_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b1;
    cpu_din = 16'h8000; cpu_req = 1'b1;
    #1 chk("wr_sel_before", 32'(nb_select), 32'd0);
    tick();
    chk("wr_sel_e0",  32'(nb_select),  32'd1);
    chk("wr_addr",    nb_addr,         32'hF9080000);
    chk("wr_be",      32'(nb_uds_lds), 32'h2);
    chk("wr_data",    32'(nb_data),    32'h8000);
    chk("wr_rw",      32'(nb_rw_n),    32'd0);
    tick();
    chk("wr_sel_e1",   32'(nb_select),   32'd1);
    chk("wr_dtack_e1", 32'(cpu_dtack_n), 32'd1);
    nb_ack_n = 1'b0;
    tick();
    chk("wr_dtack_e2", 32'(cpu_dtack_n), 32'd0);
    chk("wr_sel_e2",   32'(nb_select),   32'd0);
    chk("wr_berr_e2",  32'(cpu_berr_n),  32'd1);
    nb_ack_n = 1'b1; cpu_req = 1'b0;
    tick();
    chk("wr_dtack_rel", 32'(cpu_dtack_n), 32'd1);
    chk("wr_dout",      32'(cpu_dout),    32'd0);

    // ROM read at byte 0xF00010, then CPU holds req through DONE
    cpu_addr = 23'h780008; cpu_rw_n = 1'b1; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    cpu_req = 1'b1;
    tick();
    chk("rd_sel",  32'(nb_select),  32'd1);
    chk("rd_addr", nb_addr,         32'hF9F00010);
    chk("rd_be",   32'(nb_uds_lds), 32'h3);
    chk("rd_rw",   32'(nb_rw_n),    32'd1);
    tick();
    nb_din = 16'h1234; nb_ack_n = 1'b0;
    tick();
    chk("rd_dtack", 32'(cpu_dtack_n), 32'd0);
    chk("rd_dout",  32'(cpu_dout),    32'h1234);
    for (int i = 0; i < 10; i++) begin
      if (i == 1) nb_ack_n = 1'b1;
      tick();
      chk("hold_one_select", 32'(nb_select), 32'd0);
    end
    chk("hold_dtack", 32'(cpu_dtack_n), 32'd0);
    cpu_req = 1'b0; nb_din = 16'hDEAD;
    tick();
    chk("hold_release", 32'(cpu_dtack_n), 32'd1);

    // Write after read leaves cpu_dout untouched
    cpu_rw_n = 1'b0; cpu_din = 16'h5555; cpu_req = 1'b1;
    tick();
    tick();
    nb_ack_n = 1'b0;
    tick();
    chk("wr2_dtack", 32'(cpu_dtack_n), 32'd0);
    chk("wr2_dout",  32'(cpu_dout),    32'h1234);
    nb_ack_n = 1'b1; cpu_req = 1'b0;
    tick();

    // Timeout: no ack ever, BERR exactly 16 clocks after select rises
    cpu_req = 1'b1;
    tick();
    chk("to_sel", 32'(nb_select), 32'd1);
    for (int i = 1; i < 16; i++) tick();
    chk("to_berr_e15", 32'(cpu_berr_n), 32'd1);
    chk("to_sel_e15",  32'(nb_select),  32'd1);
    tick();
    chk("to_berr_e16",  32'(cpu_berr_n),  32'd0);
    chk("to_dtack_e16", 32'(cpu_dtack_n), 32'd1);
    chk("to_sel_e16",   32'(nb_select),   32'd0);
    chk("to_dout",      32'(cpu_dout),    32'h1234);
    tick();
    chk("to_berr_hold", 32'(cpu_berr_n), 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("to_berr_rel", 32'(cpu_berr_n), 32'd1);

    // Ack on the 16th clock wins over the timeout
    cpu_rw_n = 1'b1; nb_din = 16'hABCD; cpu_req = 1'b1;
    tick();
    for (int i = 1; i < 16; i++) tick();
    nb_ack_n = 1'b0;
    tick();
    chk("race_dtack", 32'(cpu_dtack_n), 32'd0);
    chk("race_berr",  32'(cpu_berr_n),  32'd1);
    chk("race_dout",  32'(cpu_dout),    32'hABCD);

    // Stale ack blocks relaunch
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick();
    chk("stale_sel1", 32'(nb_select), 32'd0);
    tick();
    chk("stale_sel2", 32'(nb_select), 32'd0);
    nb_ack_n = 1'b1;
    tick();
    chk("stale_launch", 32'(nb_select), 32'd1);
    tick();
    nb_din = 16'h0042; nb_ack_n = 1'b0;
    tick();
    chk("stale_dout", 32'(cpu_dout), 32'h0042);
    nb_ack_n = 1'b1; cpu_req = 1'b0;
    tick();

    // Asynchronous reset between edges during REQ
    cpu_req = 1'b1;
    tick();
    chk("ar_sel", 32'(nb_select), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("ar");
    cpu_req = 1'b0;
    tick();
    reset_n = 1'b1;
    cpu_addr = 23'h000123; cpu_rw_n = 1'b1; cpu_req = 1'b1;
    tick();
    chk("ar_rd_addr", nb_addr, 32'hF9000246);
    tick();
    nb_din = 16'h0F0F; nb_ack_n = 1'b0;
    tick();
    chk("ar_rd_dtack", 32'(cpu_dtack_n), 32'd0);
    chk("ar_rd_dout",  32'(cpu_dout),    32'h0F0F);
    nb_ack_n = 1'b1; cpu_req = 1'b0;
    tick();

    // IRQ synchronizer alongside a transaction
    nb_nmrq_n = 1'b0; cpu_req = 1'b1; nb_din = 16'h7777;
    tick();
    chk("irq_e1", 32'(slot_irq),  32'd0);
    chk("irq_sel", 32'(nb_select), 32'd1);
    tick();
    chk("irq_e2", 32'(slot_irq), 32'd1);
    nb_ack_n = 1'b0;
    tick();
    chk("irq_dtack", 32'(cpu_dtack_n), 32'd0);
    chk("irq_dout",  32'(cpu_dout),    32'h7777);
    nb_nmrq_n = 1'b1; nb_ack_n = 1'b1; cpu_req = 1'b0;
    tick();
    chk("irq_fall_e1", 32'(slot_irq),    32'd1);
    chk("irq_rel",     32'(cpu_dtack_n), 32'd1);
    tick();
    chk("irq_fall_e2", 32'(slot_irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
